// File: rtl/alu_iter_exec_if.sv
// Handshake bundle for the iterative execute-stage ALU.
// master: upstream/consumer side; slave: the ALU itself.
interface alu_iter_exec_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            Operation;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  Branch;
  logic                  Zero;

  modport master (
    output in_valid, Operation, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, Branch, Zero
  );

  modport slave (
    input  in_valid, Operation, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, Branch, Zero
  );
endinterface

// File: rtl/alu_iter_exec.sv
// Execute ALU: 1-cycle simple ops, 1-bit/cycle iterative shifts.
// Ports: clk, reset (async high), bus (slave). ALU_FAST_SHIFT_EN = barrel.
module alu_iter_exec #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  alu_iter_exec_if.slave   bus
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_BEQ = 4'b1001;
  localparam logic [3:0] OP_BNE = 4'b1010;
  localparam logic [3:0] OP_BGE = 4'b1011;
  localparam logic [3:0] OP_BLT = 4'b1100;

`ifdef ALU_FAST_SHIFT_EN
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t                state;
  logic [DATA_WIDTH-1:0] res;
  logic                  br;
  logic                  zero;

  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] diff;
  logic [SHAMT_W-1:0]    sh;
  logic                  lt;
  logic                  is_shift;
  logic [DATA_WIDTH-1:0] calc_res;
  logic                  calc_br;
  logic                  ready;
  logic                  start;

  assign a    = bus.SrcA;
  assign b    = bus.SrcB;
  assign diff = a - b;
  assign sh   = b[SHAMT_W-1:0];
  assign lt   = $signed(a) < $signed(b);

  assign is_shift = (bus.Operation == OP_SRL) ||
                    (bus.Operation == OP_SRA) ||
                    (bus.Operation == OP_SLL);

  // Shift cases only matter here when the barrel is built or sh == 0.
  always_comb begin
    calc_res = '0;
    calc_br  = 1'b0;
    case (bus.Operation)
      OP_AND: calc_res = a & b;
      OP_OR:  calc_res = a | b;
      OP_ADD: calc_res = a + b;
      OP_SUB: calc_res = diff;
      OP_XOR: calc_res = a ^ b;
`ifdef ALU_FAST_SHIFT_EN
      OP_SRL: calc_res = a >> sh;
      OP_SRA: calc_res = $unsigned($signed(a) >>> sh);
      OP_SLL: calc_res = a << sh;
`else
      OP_SRL: calc_res = a;
      OP_SRA: calc_res = a;
      OP_SLL: calc_res = a;
`endif
      OP_SLT: calc_res = {{(DATA_WIDTH-1){1'b0}}, lt};
      OP_BEQ: begin
        calc_res = diff;
        calc_br  = (a == b);
      end
      OP_BNE: begin
        calc_res = diff;
        calc_br  = (a != b);
      end
      OP_BGE: begin
        calc_res = diff;
        calc_br  = !lt;
      end
      OP_BLT: begin
        calc_res = diff;
        calc_br  = lt;
      end
      default: begin
        calc_res = '0;
        calc_br  = 1'b0;
      end
    endcase
  end

  assign ready = !reset &&
                 ((state == IDLE) ||
                  ((state == DONE) && bus.out_ready));
  assign start = bus.in_valid && ready;

`ifndef ALU_FAST_SHIFT_EN
  logic [SHAMT_W-1:0]    cnt;
  logic [3:0]            sop;
  logic [DATA_WIDTH-1:0] step;

  always_comb begin
    step = '0;
    case (sop)
      OP_SRL:  step = {1'b0, res[DATA_WIDTH-1:1]};
      OP_SRA:  step = {res[DATA_WIDTH-1], res[DATA_WIDTH-1:1]};
      default: step = {res[DATA_WIDTH-2:0], 1'b0};
    endcase
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      res   <= '0;
      br    <= 1'b0;
      zero  <= 1'b1;
`ifndef ALU_FAST_SHIFT_EN
      cnt   <= '0;
      sop   <= '0;
`endif
    end else begin
      case (state)
`ifndef ALU_FAST_SHIFT_EN
        SHIFT: begin
          res <= step;
          cnt <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            state <= DONE;
            zero  <= (step == '0);
          end
        end
`endif
        default: begin
          if (start) begin
`ifndef ALU_FAST_SHIFT_EN
            if (is_shift && (sh != '0)) begin
              state <= SHIFT;
              res   <= a;
              cnt   <= sh;
              sop   <= bus.Operation;
              br    <= 1'b0;
            end else
`endif
            begin
              state <= DONE;
              res   <= calc_res;
              br    <= calc_br;
              zero  <= (calc_res == '0);
            end
          end else if ((state == DONE) && bus.out_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state == DONE);
  assign bus.ALUResult = res;
  assign bus.Branch    = br;
  assign bus.Zero      = zero;
endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed vector bench for alu_iter_exec.
// Covers ops, shift latency, backpressure and mid-shift reset.
module tb_alu_iter_exec;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_iter_exec_if #(.DATA_WIDTH(W)) bus();

  alu_iter_exec #(.DATA_WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
    int          lat;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, act, exp);
    end
  endtask

  function automatic int slat(input int n);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    return n + 1;
`endif
  endfunction

  task automatic run_op(input vec_t t, input int idx);
    int cyc;
    cyc = 0;
    check($sformatf("v%0d in_ready", idx),
          32'(bus.in_ready), 32'd1);
    bus.Operation = t.op;
    bus.SrcA      = t.a;
    bus.SrcB      = t.b;
    bus.in_valid  = 1'b1;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      bus.in_valid  = 1'b0;
      bus.SrcA      = ~t.a;
      bus.SrcB      = ~t.b;
      bus.Operation = ~t.op;
    end while (!bus.out_valid && cyc < 100);
    check($sformatf("v%0d latency", idx), 32'(cyc), 32'(t.lat));
    check($sformatf("v%0d result", idx), bus.ALUResult, t.res);
    check($sformatf("v%0d branch", idx),
          32'(bus.Branch), 32'(t.br));
    check($sformatf("v%0d zero", idx),
          32'(bus.Zero), 32'(t.res == 32'd0));
  endtask

  initial begin
    int seen;

    tbl[0]  = '{4'b0000, 32'hF0F0_FF00, 32'h0FF0_F0F0,
                32'h00F0_F000, 1'b0, 1};
    tbl[1]  = '{4'b0001, 32'hF0F0_FF00, 32'h0FF0_F0F0,
                32'hFFF0_FFF0, 1'b0, 1};
    tbl[2]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001,
                32'h8000_0000, 1'b0, 1};
    tbl[3]  = '{4'b0011, 32'd5, 32'd5, 32'd0, 1'b0, 1};
    tbl[4]  = '{4'b0100, 32'hAAAA_5555, 32'hFFFF_0000,
                32'h5555_5555, 1'b0, 1};
    tbl[5]  = '{4'b0110, 32'h8000_0000, 32'h0000_0104,
                32'hF800_0000, 1'b0, slat(4)};
    tbl[6]  = '{4'b0101, 32'h8000_0000, 32'h0000_0104,
                32'h0800_0000, 1'b0, slat(4)};
    tbl[7]  = '{4'b0111, 32'h0000_0001, 32'h0000_001F,
                32'h8000_0000, 1'b0, slat(31)};
    tbl[8]  = '{4'b0111, 32'h0000_1234, 32'h0000_0020,
                32'h0000_1234, 1'b0, 1};
    tbl[9]  = '{4'b0110, 32'h7000_0000, 32'h0000_0003,
                32'h0E00_0000, 1'b0, slat(3)};
    tbl[10] = '{4'b0101, 32'h0000_0001, 32'h0000_0001,
                32'h0000_0000, 1'b0, slat(1)};
    tbl[11] = '{4'b1000, 32'hFFFF_FFFF, 32'h0000_0000,
                32'h0000_0001, 1'b0, 1};
    tbl[12] = '{4'b1000, 32'd5, 32'd3, 32'd0, 1'b0, 1};
    tbl[13] = '{4'b1001, 32'd7, 32'd7, 32'd0, 1'b1, 1};
    tbl[14] = '{4'b1010, 32'd7, 32'd7, 32'd0, 1'b0, 1};
    tbl[15] = '{4'b1011, 32'hFFFF_FFFF, 32'h0000_0000,
                32'hFFFF_FFFF, 1'b0, 1};
    tbl[16] = '{4'b1100, 32'hFFFF_FFFF, 32'h0000_0000,
                32'hFFFF_FFFF, 1'b1, 1};
    tbl[17] = '{4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'h0000_0000, 1'b0, 1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.Operation = 4'd0;
    bus.SrcA      = '0;
    bus.SrcB      = '0;

    @(posedge clk);
    #1;
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst zero", 32'(bus.Zero), 32'd1);
    check("rst result", bus.ALUResult, 32'd0);
    check("rst branch", 32'(bus.Branch), 32'd0);
    check("rst in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post rst in_ready", 32'(bus.in_ready), 32'd1);

    bus.out_ready = 1'b1;
    for (int i = 0; i < 18; i++) run_op(tbl[i], i);

    // Backpressure with a held follow-on op
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.Operation = 4'b0100;
    bus.SrcA      = 32'h1234_5678;
    bus.SrcB      = 32'hFFFF_FFFF;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.Operation = 4'b0010;
    bus.SrcA      = 32'd2;
    bus.SrcB      = 32'd3;
    check("bp xor valid", 32'(bus.out_valid), 32'd1);
    check("bp xor result", bus.ALUResult, 32'hEDCB_A987);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp hold%0d result", i),
            bus.ALUResult, 32'hEDCB_A987);
      check($sformatf("bp hold%0d in_ready", i),
            32'(bus.in_ready), 32'd0);
      check($sformatf("bp hold%0d valid", i),
            32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp next valid", 32'(bus.out_valid), 32'd1);
    check("bp next result", bus.ALUResult, 32'd5);

    // Reset mid-shift: SLL by 20, reset after 5 shift cycles
    bus.Operation = 4'b0111;
    bus.SrcA      = 32'd1;
    bus.SrcB      = 32'd20;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst zero", 32'(bus.Zero), 32'd1);
    check("midrst result", bus.ALUResult, 32'd0);
    check("midrst in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst rel in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("midrst no result", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
